uart_transmitter: RTL

- Serial UART transmit stage. It sits directly upstream of uart_receiver on the serial line and drives the `signal_in` of that block.
- Accepts parallel bytes over a valid/ready handshake and serialises each one as a frame: start bit (0), DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
- Line idles high.

---
 rtl/uart_transmitter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// UART transmit stage: one byte per frame (start, data LSB first, optional parity, stop), line idles high.
// Latency: signal_out drops for the start bit on the cycle after the accepting edge (registered output).
// Backpressure: data_ready only in IDLE or on the final stop cycle, so frames can run back to back.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity symbol between data and stop.
module uart_transmitter #(
    parameter int CYCLES_PER_SYMBOL = 125_000_000 / 115_200,
    parameter int DATA_BITS         = 8,
    parameter int STOP_BITS         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 signal_out,
    output logic                 busy
);

    // Symbol counter counts 0..CYCLES_PER_SYMBOL-1; the extra bit keeps CYCLES_PER_SYMBOL=1 legal.
    localparam int CNT_W = $clog2(CYCLES_PER_SYMBOL) + 1;
    // One index register walks both the data bits and the stop symbols, so size it for the larger.
    localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_SYMBOL - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic sym_end;
    logic last_stop;
    logic accept;

    // Last cycle of the current symbol.
    assign sym_end   = (cnt_q == CNT_LAST);
    // Final cycle of the final stop symbol: the only mid-frame point where a new byte may enter.
    assign last_stop = (state_q == ST_STOP) && (idx_q == STOP_LAST) && sym_end;

    assign data_ready = ~rst & ((state_q == ST_IDLE) | last_stop);
    assign accept     = data_valid & data_ready;

    assign signal_out = tx_q;
    assign busy       = (state_q != ST_IDLE);

    // Next-state logic: walks the frame symbol by symbol and precomputes the next line level.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != ST_IDLE) begin
            cnt_d = sym_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                idx_d = '0;
            end

            ST_START: begin
                if (sym_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            ST_DATA: begin
                if (sym_end) begin
                    if (idx_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // The line always shows bit 0 of the shift register.
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_d[0];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (sym_end) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif

            ST_STOP: begin
                tx_d = 1'b1;
                if (sym_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Acceptance can only happen in IDLE or on the last stop cycle; it overrides both
        // and starts the next frame with its start bit on the following cycle.
        if (accept) begin
            state_d  = ST_START;
            cnt_d    = '0;
            idx_d    = '0;
            shift_d  = data_in;
            tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^data_in;
`endif
        end
    end

    // State and datapath registers; reset aborts any frame and returns the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
